mul_seq_ctrl: RTL and testbench

Execute-stage sequencer for the shared 32-bit RV32M multiplier. It accepts MUL/MULH/MULHSU/MULHU requests from the pipeline and drives the multiplier's select and operand inputs. It stalls the pipeline until the multiplier's `ready` arrives, then returns the result as a one-cycle response. A one-entry result cache answers an exact repeat of the last completed request with zero added latency.

---
 rtl/mul_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_mul_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Execute-stage sequencer for the shared RV32M multiplier: holds the pipeline
// while the multiplier works and answers exact repeats from a one-entry cache.
module mul_seq_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        err,
    output logic [2:0]  mul_mulsel,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_ready,
    input  logic [31:0] mul_res
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, COOL} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    lat_f3;
    logic [31:0]   res_q;
    logic          err_q;
    logic          cache_valid;
    logic [2:0]    cache_f3;
    logic [31:0]   cache_a;
    logic [31:0]   cache_b;
    logic [31:0]   cache_res;

    logic is_mul;
    logic hit;

    assign is_mul = req_valid & ~req_funct3[2] & ~flush;
    assign hit    = (state == IDLE) & is_mul & cache_valid & (req_funct3 == cache_f3)
                  & (req_a == cache_a) & (req_b == cache_b);
    assign err    = err_q;

    // Combinational outputs are forced low while rst is high so the pipeline
    // sees a quiet block even if a request is still presented.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    stall      = is_mul & ~hit;
                    resp_valid = hit;
                    if (hit) resp_data = cache_res;
                end
                BUSY: stall = 1'b1;
                DONE: begin
                    resp_valid = 1'b1;
                    resp_data  = res_q;
                end
                COOL: stall = is_mul;
                default: ;
            endcase
        end
    end

    // NOTE: the cache is a handful of flops rather than a RAM, so it is reset
    // along with everything else; only valid really matters for correctness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_f3      <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            cache_valid <= 1'b0;
            cache_f3    <= '0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_res   <= '0;
            mul_mulsel  <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every register sees pre-edge values.
            unique case (state)
                IDLE: begin
                    if (is_mul && !hit) begin
                        mul_mulsel <= req_funct3 + 3'd1;
                        mul_a      <= req_a;
                        mul_b      <= req_b;
                        lat_f3     <= req_funct3;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        mul_mulsel <= '0;
                        state      <= COOL;
                    end else if (mul_ready) begin
                        res_q       <= mul_res;
                        cache_valid <= 1'b1;
                        cache_f3    <= lat_f3;
                        cache_a     <= mul_a;
                        cache_b     <= mul_b;
                        cache_res   <= mul_res;
                        mul_mulsel  <= '0;
                        state       <= DONE;
                    end else if (cnt + CW'(1) == CW'(TIMEOUT)) begin
                        // Timeout reuses DONE to emit a zero response and unblock the pipeline.
                        err_q       <= 1'b1;
                        res_q       <= '0;
                        cache_valid <= 1'b0;
                        mul_mulsel  <= '0;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: state <= COOL;
                COOL: if (!mul_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural multiplier model
// (ready two cycles after select, held two cycles, optional never-ready mode).
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        err;
    logic [2:0]  mul_mulsel;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic [31:0] mul_res;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   age;
    int   rdy_left;
    bit   dead = 1'b0;

    mul_seq_ctrl #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_funct3 (req_funct3),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .err        (err),
        .mul_mulsel (mul_mulsel),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ready  (mul_ready),
        .mul_res    (mul_res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_mul(input logic [2:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] sa, ua, sbv, ub, p;
        sa  = {{32{a[31]}}, a};
        ua  = {32'b0, a};
        sbv = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        case (sel)
            3'd1: begin p = ua * ub;  return p[31:0];  end
            3'd2: begin p = sa * sbv; return p[63:32]; end
            3'd3: begin p = sa * ub;  return p[63:32]; end
            3'd4: begin p = ua * ub;  return p[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    // Multiplier model: ready rises two cycles after a nonzero select appears.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_ready <= 1'b0;
            mul_res   <= '0;
            age       <= 0;
            rdy_left  <= 0;
        end else if (rdy_left != 0) begin
            rdy_left <= rdy_left - 1;
            if (rdy_left == 1) mul_ready <= 1'b0;
            age <= 0;
        end else if (mul_mulsel == 3'd0 || dead) begin
            age <= 0;
        end else if (age == 1) begin
            mul_ready <= 1'b1;
            rdy_left  <= 2;
            mul_res   <= ref_mul(mul_mulsel, mul_a, mul_b);
            age       <= 0;
        end else begin
            age <= age + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every response strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (resp_valid) begin
                if (scb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: actual data %h required no response (cycle %0d)",
                             resp_data, cyc);
                end else begin
                    e = scb.pop_front();
                    check("resp_data", resp_data, e.data);
                    check("resp_cycle", cyc, e.cyc);
                end
            end else begin
                check("resp_data_idle", resp_data, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        check(name, scb.size(), 0);
    endtask

    // Cache-miss request presented in the current cycle; returns in cycle +6 (IDLE).
    task automatic do_miss(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res);
        logic [2:0] sel;
        int c0;
        c0  = cyc;
        sel = f3 + 3'd1;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        scb.push_back('{res, c0 + 4});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("miss_stall", stall, 1);
            check("miss_mulsel", mul_mulsel, (k == 0) ? 3'd0 : sel);
            if (k > 0) begin
                check("miss_mul_a", mul_a, a);
                check("miss_mul_b", mul_b, b);
            end
            step();
        end
        @(negedge clk);
        check("done_stall", stall, 0);
        check("done_mulsel", mul_mulsel, 0);
        step();
        req_valid = 1'b0;
        step();
        wait_drain("miss_drained");
    endtask

    task automatic do_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int n);
        for (int i = 0; i < n; i++) begin
            req_valid  = 1'b1;
            req_funct3 = f3;
            req_a      = a;
            req_b      = b;
            scb.push_back('{res, cyc});
            @(negedge clk);
            check("hit_stall", stall, 0);
            check("hit_mulsel", mul_mulsel, 0);
            step();
        end
        req_valid = 1'b0;
        wait_drain("hit_drained");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_mulsel"}, mul_mulsel, 0);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct3 = '0;
        req_a      = '0;
        req_b      = '0;
        flush      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        step();

        do_miss(3'b000, 32'd7, 32'd6, 32'd42);
        do_miss(3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
        do_miss(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_miss(3'b011, 32'h8000_0000, 32'd2, 32'h0000_0001);
        do_hit(3'b011, 32'h8000_0000, 32'd2, 32'h0000_0001, 2);

        // Divide ops are ignored in IDLE.
        req_valid = 1'b1; req_funct3 = 3'b100; req_a = 32'd9; req_b = 32'd3;
        @(negedge clk);
        check("div_stall", stall, 0);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("div_mulsel", mul_mulsel, 0);
        step();

        // Flush in cycle 2 of a miss: no response, select drops from cycle 3.
        req_valid = 1'b1; req_funct3 = 3'b000; req_a = 32'd3; req_b = 32'd5;
        step();
        @(negedge clk);
        check("flush_mulsel_c1", mul_mulsel, 3'd1);
        step();
        flush = 1'b1;
        @(negedge clk);
        check("flush_stall_c2", stall, 1);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_mulsel_c3", mul_mulsel, 0);
        step(); step(); step();
        do_hit(3'b011, 32'h8000_0000, 32'd2, 32'h0000_0001, 1);
        do_miss(3'b000, 32'd3, 32'd5, 32'd15);

        // Multiplier never ready: timeout response of 0 at cycle 16.
        dead = 1'b1;
        c0 = cyc;
        req_valid = 1'b1; req_funct3 = 3'b000; req_a = 32'd9; req_b = 32'd9;
        scb.push_back('{32'h0, c0 + 16});
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("to_stall", stall, 1);
            if (k == 15) check("to_err_early", err, 0);
            step();
        end
        @(negedge clk);
        check("to_err_set", err, 1);
        check("to_stall_done", stall, 0);
        step();
        req_valid = 1'b0;
        dead = 1'b0;
        step();
        wait_drain("to_drained");
        do_miss(3'b000, 32'd3, 32'd5, 32'd15);
        check("err_sticky", err, 1);

        // Reset in cycle 2 of a miss.
        req_valid = 1'b1; req_funct3 = 3'b000; req_a = 32'd11; req_b = 32'd13;
        step(); step();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        req_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        step();
        do_miss(3'b000, 32'd11, 32'd13, 32'd143);
        check("err_after_rst", err, 0);

        repeat (3) step();
        wait_drain("final_drained");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
